bfsk_tx_sched: RTL and testbench



---
 rtl/bfsk_pkg.sv | 35 +++
 rtl/bfsk_tx_sched_if.sv | 10 +
 rtl/bfsk_bit_timer.sv | 29 ++
 rtl/bfsk_tx_sched.sv | 210 +++++++++++++++++++++
 tb/tb_bfsk_tx_sched.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bfsk_pkg.sv
// Shared types and constants for the BFSK transmit scheduler and NCO.
// The CRC helper exists only when BFSK_TX_CRC8_EN is defined.
package bfsk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_PRE,
        ST_DATA,
`ifdef BFSK_TX_CRC8_EN
        ST_CRC,
`endif
        ST_GAP
    } state_e;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'hAA;
    localparam logic [7:0]  CRC8_POLY     = 8'h07;
    localparam logic [31:0] DEF_MARK_INC  = 32'd10737418;
    localparam logic [31:0] DEF_SPACE_INC = 32'd21474836;

`ifdef BFSK_TX_CRC8_EN
    function automatic logic [7:0] crc8_byte(
        input logic [7:0] crc,
        input logic [7:0] data
    );
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        end
        return c;
    endfunction
`endif

endpackage

// File: rtl/bfsk_tx_sched_if.sv
// Byte-stream requester channel: valid/data/last offered, ready accepts.
interface bfsk_tx_sched_if;
    logic       valid;
    logic [7:0] data;
    logic       last;
    logic       ready;

    modport master (output valid, data, last, input ready);
    modport slave  (input valid, data, last, output ready);
endinterface

// File: rtl/bfsk_bit_timer.sv
// Bit-period counter: strobe on the first cycle, end on the last cycle.
module bfsk_bit_timer #(
    parameter int unsigned CLK_PER_BIT = 1600
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic bit_strobe,
    output logic bit_end
);

    localparam logic [15:0] LAST = 16'(CLK_PER_BIT - 1);

    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = 16'd0;
        if (en && cnt_q != LAST) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= 16'd0;
        else        cnt_q <= cnt_d;
    end

    assign bit_strobe = en && (cnt_q == 16'd0);
    assign bit_end    = en && (cnt_q == LAST);

endmodule

// File: rtl/bfsk_tx_sched.sv
// Round-robin frame arbiter and MSB-first BFSK serializer for two requesters.
// Define BFSK_TX_CRC8_EN to append a CRC-8 trailer to completed frames.
module bfsk_tx_sched
    import bfsk_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT    = 1600,
    parameter logic [31:0] MARK_INC       = DEF_MARK_INC,
    parameter logic [31:0] SPACE_INC      = DEF_SPACE_INC,
    parameter int unsigned PREAMBLE_BYTES = 2,
    parameter int unsigned GAP_CYCLES     = 12000
) (
    input  logic           clk,
    input  logic           rst_n,
    bfsk_tx_sched_if.slave a,
    bfsk_tx_sched_if.slave b,
    output logic [31:0]    nco_inc,
    output logic           nco_en,
    output logic           nco_phase_clr,
    output logic           tx_bit,
    output logic           bit_strobe,
    output logic           busy,
    output logic           grant_id,
    output logic           underrun
);

    localparam logic [3:0]  PRE_LAST = 4'(PREAMBLE_BYTES - 1);
    localparam logic [19:0] GAP_LAST = 20'(GAP_CYCLES - 1);

    state_e      state_q, state_d;
    logic        grant_q, grant_d;
    logic        lgrant_q, lgrant_d;
    logic [7:0]  byte_q, byte_d;
    logic        last_q, last_d;
    logic [7:0]  sh_q, sh_d;
    logic [2:0]  idx_q, idx_d;
    logic [3:0]  pre_q, pre_d;
    logic [19:0] gap_q, gap_d;
`ifdef BFSK_TX_CRC8_EN
    logic [7:0]  crc_q, crc_d;
`endif

    logic       tx_on, bit_end, arb_grant, pick, take;
    logic       in_valid, in_last;
    logic [7:0] in_data;

    bfsk_bit_timer #(
        .CLK_PER_BIT(CLK_PER_BIT)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (tx_on),
        .bit_strobe(bit_strobe),
        .bit_end   (bit_end)
    );

    // Only-valid wins; a tie goes to the side not served last.
    assign arb_grant = (a.valid && b.valid) ? ~lgrant_q : b.valid;
    assign pick      = (state_q == ST_ARB) ? arb_grant : grant_q;
    assign in_valid  = pick ? b.valid : a.valid;
    assign in_data   = pick ? b.data  : a.data;
    assign in_last   = pick ? b.last  : a.last;
    assign a.ready   = take && !pick;
    assign b.ready   = take &&  pick;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        lgrant_d = lgrant_q;
        byte_d   = byte_q;
        last_d   = last_q;
        sh_d     = sh_q;
        idx_d    = idx_q;
        pre_d    = pre_q;
        gap_d    = gap_q;
`ifdef BFSK_TX_CRC8_EN
        crc_d    = crc_q;
`endif
        take     = 1'b0;
        underrun = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (a.valid || b.valid) state_d = ST_ARB;
            end
            ST_ARB: begin
                take     = 1'b1;
                grant_d  = arb_grant;
                lgrant_d = arb_grant;
                byte_d   = in_data;
                last_d   = in_last;
                sh_d     = PREAMBLE_BYTE;
                idx_d    = 3'd0;
                pre_d    = 4'd0;
`ifdef BFSK_TX_CRC8_EN
                crc_d    = crc8_byte(8'h00, in_data);
`endif
                state_d  = ST_PRE;
            end
            ST_PRE: begin
                if (bit_end) begin
                    sh_d  = sh_q << 1;
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        if (pre_q == PRE_LAST) begin
                            sh_d    = byte_q;
                            state_d = ST_DATA;
                        end else begin
                            sh_d  = PREAMBLE_BYTE;
                            pre_d = pre_q + 4'd1;
                        end
                    end
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    sh_d  = sh_q << 1;
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        gap_d = 20'd0;
                        if (last_q) begin
`ifdef BFSK_TX_CRC8_EN
                            sh_d    = crc_q;
                            state_d = ST_CRC;
`else
                            state_d = ST_GAP;
`endif
                        end else begin
                            take = 1'b1;
                            if (in_valid) begin
                                sh_d   = in_data;
                                last_d = in_last;
`ifdef BFSK_TX_CRC8_EN
                                crc_d  = crc8_byte(crc_q, in_data);
`endif
                            end else begin
                                underrun = 1'b1;
                                state_d  = ST_GAP;
                            end
                        end
                    end
                end
            end
`ifdef BFSK_TX_CRC8_EN
            ST_CRC: begin
                if (bit_end) begin
                    sh_d  = sh_q << 1;
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        gap_d   = 20'd0;
                        state_d = ST_GAP;
                    end
                end
            end
`endif
            ST_GAP: begin
                gap_d = gap_q + 20'd1;
                if (gap_q == GAP_LAST) begin
                    gap_d   = 20'd0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            grant_q  <= 1'b0;
            lgrant_q <= 1'b1;
            byte_q   <= 8'h00;
            last_q   <= 1'b0;
            sh_q     <= 8'h00;
            idx_q    <= 3'd0;
            pre_q    <= 4'd0;
            gap_q    <= 20'd0;
`ifdef BFSK_TX_CRC8_EN
            crc_q    <= 8'h00;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            lgrant_q <= lgrant_d;
            byte_q   <= byte_d;
            last_q   <= last_d;
            sh_q     <= sh_d;
            idx_q    <= idx_d;
            pre_q    <= pre_d;
            gap_q    <= gap_d;
`ifdef BFSK_TX_CRC8_EN
            crc_q    <= crc_d;
`endif
        end
    end

`ifdef BFSK_TX_CRC8_EN
    assign tx_on = (state_q == ST_PRE) || (state_q == ST_DATA)
                || (state_q == ST_CRC);
`else
    assign tx_on = (state_q == ST_PRE) || (state_q == ST_DATA);
`endif

    assign tx_bit        = tx_on && sh_q[7];
    assign nco_inc       = !tx_on ? 32'd0 : (sh_q[7] ? MARK_INC : SPACE_INC);
    assign nco_en        = tx_on;
    assign nco_phase_clr = (state_q == ST_PRE) && (pre_q == 4'd0)
                        && (idx_q == 3'd0) && bit_strobe;
    assign busy          = (state_q != ST_IDLE);
    assign grant_id      = (state_q == ST_ARB) ? arb_grant : grant_q;

endmodule

// File: tb/tb_bfsk_tx_sched.sv
// Directed + randomized frame checks against an on-air bit-stream model.
`timescale 1ns/1ps
module tb_bfsk_tx_sched;

    localparam int          CPB   = 16;
    localparam int          PB    = 1;
    localparam int          GAPC  = 20;
    localparam logic [31:0] MARK  = 32'd10737418;
    localparam logic [31:0] SPACE = 32'd21474836;
    localparam logic [40:0] GMASK = 41'(1) << 39;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] nco_inc;
    logic        nco_en, nco_phase_clr, tx_bit, bit_strobe;
    logic        busy, grant_id, underrun;

    always #5 clk = ~clk;

    bfsk_tx_sched_if a_if();
    bfsk_tx_sched_if b_if();

    bfsk_tx_sched #(
        .CLK_PER_BIT   (CPB),
        .MARK_INC      (MARK),
        .SPACE_INC     (SPACE),
        .PREAMBLE_BYTES(PB),
        .GAP_CYCLES    (GAPC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .a            (a_if),
        .b            (b_if),
        .nco_inc      (nco_inc),
        .nco_en       (nco_en),
        .nco_phase_clr(nco_phase_clr),
        .tx_bit       (tx_bit),
        .bit_strobe   (bit_strobe),
        .busy         (busy),
        .grant_id     (grant_id),
        .underrun     (underrun)
    );

    // Driver queues ({last,data}) and model copies of pending bytes.
    logic [8:0] qa[$], qb[$], ea[$], eb[$];
    bit         lg = 1'b1;
    int         n_cmp = 0;
    int         n_bad = 0;

    initial begin
        bit acc;
        a_if.valid = 1'b0; a_if.data = 8'h00; a_if.last = 1'b0;
        forever begin
            @(negedge clk);
            acc = a_if.valid && a_if.ready;
            @(posedge clk);
            #1;
            if (acc && qa.size() > 0) void'(qa.pop_front());
            a_if.valid = (qa.size() > 0);
            if (a_if.valid) {a_if.last, a_if.data} = qa[0];
            else {a_if.last, a_if.data} = 9'($urandom);
        end
    end

    initial begin
        bit acc;
        b_if.valid = 1'b0; b_if.data = 8'h00; b_if.last = 1'b0;
        forever begin
            @(negedge clk);
            acc = b_if.valid && b_if.ready;
            @(posedge clk);
            #1;
            if (acc && qb.size() > 0) void'(qb.pop_front());
            b_if.valid = (qb.size() > 0);
            if (b_if.valid) {b_if.last, b_if.data} = qb[0];
            else {b_if.last, b_if.data} = 9'($urandom);
        end
    end

    function automatic logic [40:0] obs();
        return {busy, grant_id, nco_en, nco_phase_clr, bit_strobe, tx_bit,
                underrun, a_if.ready, b_if.ready, nco_inc};
    endfunction

    function automatic logic [40:0] mk(input bit bz, gid, en, clr, stb,
                                       bt, und, ra, rb,
                                       input logic [31:0] inc);
        return {bz, gid, en, clr, stb, bt, und, ra, rb, inc};
    endfunction

    task automatic chk(input string tag, input logic [40:0] o,
                       input logic [40:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic push(input bit who, input logic [8:0] x);
        if (who) begin qb.push_back(x); eb.push_back(x); end
        else     begin qa.push_back(x); ea.push_back(x); end
    endtask

    task automatic wait_busy(input string tag, output bit ok);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!busy && t < 300);
        chk({tag, "/start"}, {40'b0, busy}, 41'd1);
        ok = busy;
    endtask

    // Arbitrate per the round-robin rule, build the on-air bit list,
    // then walk ARB, every bit window, the gap and the return to idle.
    task automatic check_frame(input string tag);
        bit         va, vb, g, abort, ok, wbad;
        logic [8:0] x;
        logic [8:0] fr[$];
        bit         bits[$];
        logic [40:0] o, e, wo, we;
`ifdef BFSK_TX_CRC8_EN
        logic [7:0] crc;
        bit         fb;
`endif
        va = ea.size() > 0;
        vb = eb.size() > 0;
        g  = (va && vb) ? ~lg : vb;
        lg = g;
        do begin
            x = g ? eb.pop_front() : ea.pop_front();
            fr.push_back(x);
        end while (!x[8] && (g ? eb.size() : ea.size()) > 0);
        abort = !x[8];
        for (int p = 0; p < PB; p++)
            for (int j = 7; j >= 0; j--) bits.push_back(j % 2 == 1);
        foreach (fr[i])
            for (int j = 7; j >= 0; j--) bits.push_back(fr[i][j]);
`ifdef BFSK_TX_CRC8_EN
        if (!abort) begin
            crc = 8'h00;
            foreach (fr[i])
                for (int j = 7; j >= 0; j--) begin
                    fb  = crc[7] ^ fr[i][j];
                    crc = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
                end
            for (int j = 7; j >= 0; j--) bits.push_back(crc[j]);
        end
`endif
        wait_busy(tag, ok);
        if (!ok) return;
        chk({tag, "/arb"}, obs(), mk(1, g, 0, 0, 0, 0, 0, !g, g, 32'd0));
        wbad = 1'b0;
        wo = '0;
        we = '0;
        for (int k = 0; k < bits.size() * CPB; k++) begin
            int bi, c, d;
            bit b, eob, rdy, und;
            bi  = k / CPB;
            c   = k % CPB;
            d   = bi / 8 - PB;
            b   = bits[bi];
            eob = (c == CPB - 1) && (bi % 8 == 7);
            rdy = eob && d >= 0 && d < int'(fr.size())
               && (d < int'(fr.size()) - 1 || abort);
            und = eob && abort && d == int'(fr.size()) - 1;
            @(negedge clk);
            o = obs();
            e = mk(1, g, 1, k == 0, c == 0, b, und, rdy && !g, rdy && g,
                   b ? MARK : SPACE);
            if (c == 0) wbad = 1'b0;
            if (!wbad) begin
                wo = o; we = e; wbad = (o !== e);
            end
            if (c == CPB - 1) chk($sformatf("%s/bit%0d", tag, bi), wo, we);
        end
        wbad = 1'b0;
        for (int k = 0; k < GAPC; k++) begin
            @(negedge clk);
            o = obs();
            e = mk(1, g, 0, 0, 0, 0, 0, 0, 0, 32'd0);
            if (!wbad) begin
                wo = o; we = e; wbad = (o !== e);
            end
        end
        chk({tag, "/gap"}, wo, we);
        @(negedge clk);
        chk({tag, "/idle"}, obs() & ~GMASK, 41'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] r0, r1;
        bit ok;
        repeat (3) @(negedge clk);
        chk("reset", obs(), 41'd0);
        rst_n = 1'b1;

        push(0, {1'b1, 8'hC5});
        check_frame("c5");

        push(0, {1'b1, 8'($urandom)});
        push(1, {1'b1, 8'($urandom)});
        check_frame("rr1");
        check_frame("rr2");
        push(0, {1'b1, 8'($urandom)});
        push(1, {1'b1, 8'($urandom)});
        check_frame("rr3");
        check_frame("rr4");

        push(0, {1'b0, 8'h01});
        push(0, {1'b0, 8'h02});
        push(0, {1'b1, 8'h03});
        check_frame("three");

        push(0, {1'b0, 8'h10});
        check_frame("abort");

        r0 = 8'($urandom);
        r1 = 8'($urandom);
        push(0, {1'b0, r0});
        push(0, {1'b1, r1});
        wait_busy("rst", ok);
        if (ok) begin
            repeat (1 + PB * 8 * CPB + 3 * CPB + 5) @(negedge clk);
            chk("rst/bit3", {40'b0, tx_bit}, {40'b0, r0[4]});
            #2 rst_n = 1'b0;
            #1 chk("rst/async", obs(), 41'd0);
            qa.delete(); ea.delete();
            lg = 1'b1;
            push(0, {1'b0, r0});
            push(0, {1'b1, r1});
            @(negedge clk);
            chk("rst/held", obs(), 41'd0);
            rst_n = 1'b1;
            check_frame("rst/refr");
        end

        for (int it = 0; it < 8; it++) begin
            int m, len;
            bit ab;
            m = $urandom_range(1, 3);
            for (int w = 0; w < 2; w++) begin
                if (m[w]) begin
                    len = $urandom_range(1, 3);
                    ab  = ($urandom_range(0, 3) == 0);
                    for (int i = 0; i < len; i++)
                        push(w[0], {(i == len - 1) && !ab, 8'($urandom)});
                end
            end
            while (ea.size() > 0 || eb.size() > 0)
                check_frame($sformatf("rnd%0d", it));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
